alu_muldiv: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Executes the existing logic/arithmetic opcodes in 1 cycle.
- Adds an iterative unsigned multiplier/divider with HI/LO result registers and MFHI/MFLO reads.
- Sits in the execute stage behind a valid/ready handshake so the control unit can stall on multi-cycle operations.

---
 rtl/alu_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered execute-stage ALU with an iterative multiplier/divider and HI/LO registers
// Ports: clk, rst (async, active-high); in_valid/in_ready request handshake; alu_opcode, a, b operands;
//        out_valid one-cycle result pulse; alu_out/zero registered result; busy while iterating; hi/lo registers.
// Optional: define SIGNED_MULDIV_EN to add signed MULT (1101) and DIV (1110).
module alu_muldiv #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MULTU = 4'b1000, OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_MFHI = 4'b1010, OP_MFLO = 4'b1011;
`ifdef SIGNED_MULDIV_EN
   localparam logic [3:0] OP_MULT = 4'b1101, OP_DIV = 4'b1110;
`endif
   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
`ifdef SIGNED_MULDIV_EN
      FIX,
`endif
      DONE
   } state_t;
   state_t state_q, state_d, post;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, alu_out_q, alu_out_d, res;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic zero_q, zero_d, out_valid_q, out_valid_d, last, ge;
   logic [WIDTH:0] sum, trial, diff;
`ifdef SIGNED_MULDIV_EN
   logic sgn_q, sgn_d, mul_q, mul_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign post = sgn_q ? FIX : DONE;
`else
   assign post = DONE;
`endif
   assign in_ready = state_q == IDLE;
   assign busy = state_q == MUL || state_q == DIV;
   assign out_valid = out_valid_q;
   assign alu_out = alu_out_q;
   assign zero = zero_q;
   assign hi = hi_q;
   assign lo = lo_q;
   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
   assign trial = acc_q[2*WIDTH-1:WIDTH-1];
   assign diff = trial - {1'b0, opnd_q};
   assign ge = trial >= {1'b0, opnd_q};
   assign last = cnt_q == CNT_W'(WIDTH - 1);
   always_comb begin
      res = a;
      case (alu_opcode)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_SLT:  res = WIDTH'(a < b);
         OP_NOR:  res = ~(a | b);
         OP_MFHI: res = hi_q;
         OP_MFLO: res = lo_q;
         default: res = a;
      endcase
   end
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      opnd_d = opnd_q;
      cnt_d = cnt_q;
      hi_d = hi_q;
      lo_d = lo_q;
      alu_out_d = alu_out_q;
      zero_d = zero_q;
      out_valid_d = 1'b0;
`ifdef SIGNED_MULDIV_EN
      sgn_d = sgn_q;
      mul_d = mul_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            if (alu_opcode == OP_MULTU || alu_opcode == OP_DIVU) begin
               state_d = alu_opcode == OP_MULTU ? MUL : DIV;
               acc_d = {{WIDTH{1'b0}}, alu_opcode == OP_MULTU ? b : a};
               opnd_d = alu_opcode == OP_MULTU ? a : b;
               cnt_d = '0;
`ifdef SIGNED_MULDIV_EN
               sgn_d = 1'b0;
            end else if (alu_opcode == OP_MULT || alu_opcode == OP_DIV) begin
               state_d = alu_opcode == OP_MULT ? MUL : DIV;
               acc_d = {{WIDTH{1'b0}}, alu_opcode == OP_MULT ? b_mag : a_mag};
               opnd_d = alu_opcode == OP_MULT ? a_mag : b_mag;
               cnt_d = '0;
               sgn_d = 1'b1;
               mul_d = alu_opcode == OP_MULT;
               // divide by zero keeps the all-ones quotient; remainder follows the dividend
               neg_lo_d = (a[WIDTH-1] ^ b[WIDTH-1]) & (alu_opcode == OP_MULT || |b);
               neg_hi_d = alu_opcode == OP_MULT ? a[WIDTH-1] ^ b[WIDTH-1] : a[WIDTH-1];
`endif
            end else begin
               alu_out_d = res;
               zero_d = res == '0;
               out_valid_d = 1'b1;
            end
         end
         MUL: begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            state_d = last ? post : MUL;
         end
         DIV: begin
            acc_d = {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
            cnt_d = cnt_q + CNT_W'(1);
            state_d = last ? post : DIV;
         end
`ifdef SIGNED_MULDIV_EN
         FIX: begin
            acc_d = mul_q ? (neg_lo_q ? -acc_q : acc_q) :
                    {neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
                     neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
            state_d = DONE;
         end
`endif
         DONE: begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
            alu_out_d = acc_q[WIDTH-1:0];
            zero_d = acc_q[WIDTH-1:0] == '0;
            out_valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         opnd_q <= '0;
         cnt_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         alu_out_q <= '0;
         zero_q <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SIGNED_MULDIV_EN
         sgn_q <= 1'b0;
         mul_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         opnd_q <= opnd_d;
         cnt_q <= cnt_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         alu_out_q <= alu_out_d;
         zero_q <= zero_d;
         out_valid_q <= out_valid_d;
`ifdef SIGNED_MULDIV_EN
         sgn_q <= sgn_d;
         mul_q <= mul_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv at WIDTH=32
module tb_alu_muldiv;
   logic clk, rst, in_valid, in_ready, out_valid, zero, busy;
   logic [3:0] alu_opcode;
   logic [31:0] a, b, alu_out, hi, lo;
   int n_cmp = 0, n_err = 0;
   int lat, busy_n, bad, extra, ov_n;
   alu_muldiv dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_opcode(alu_opcode),
      .a(a), .b(b), .out_valid(out_valid), .alu_out(alu_out), .zero(zero), .busy(busy),
      .hi(hi), .lo(lo)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      in_valid = 1'b1;
      alu_opcode = op;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask
   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      issue(op, x, y);
      chk({tag, "_out"}, alu_out, exp);
      chk({tag, "_valid"}, out_valid, 1'b1);
   endtask
   // junk keeps a request asserted while the unit is busy; it must be dropped
   task automatic run_multi(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic junk);
      lat = 0;
      bad = 0;
      extra = 0;
      issue(op, x, y);
      busy_n = busy ? 1 : 0;
      if (in_ready) bad++;
      if (junk) begin
         in_valid = 1'b1;
         alu_opcode = 4'b0010;
         a = 32'h1;
         b = 32'h1;
      end
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (busy) busy_n++;
         if (busy && in_ready) bad++;
         if (out_valid) begin
            lat = i;
            in_valid = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid) extra++;
   endtask
   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      alu_opcode = 4'b0;
      a = '0;
      b = '0;
      #1;
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out", alu_out, 32'h0);
      chk("rst_zero", zero, 1'b1);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      single("add", 4'b0010, 32'd7, 32'd5, 32'd12);
      single("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE);
      single("slt", 4'b0111, 32'd3, 32'd9, 32'd1);
      single("nor", 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk("idle_valid", out_valid, 1'b0);
      chk("hold_out", alu_out, 32'hFFFF_FFFF);
      single("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000);
      single("or", 4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0);
      single("sub0", 4'b0110, 32'd5, 32'd5, 32'd0);
      chk("sub0_zero", zero, 1'b1);
      single("slt_no", 4'b0111, 32'd9, 32'd3, 32'd0);
      single("slt_uns", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0);
      single("dflt", 4'b0011, 32'hDEAD, 32'h1, 32'hDEAD);
      run_multi(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("mul_lat", lat, 33);
      chk("mul_busy", busy_n, 32);
      chk("mul_ready", bad, 0);
      chk("mul_extra", extra, 0);
      chk("mul_hi", hi, 32'hFFFF_FFFE);
      chk("mul_lo", lo, 32'h1);
      chk("mul_out", alu_out, 32'h1);
      chk("mul_zero", zero, 1'b0);
      single("add_keep", 4'b0010, 32'd1, 32'd1, 32'd2);
      chk("keep_hi", hi, 32'hFFFF_FFFE);
      chk("keep_lo", lo, 32'h1);
      run_multi(4'b1001, 32'd100, 32'd7, 1'b0);
      chk("div_lat", lat, 33);
      chk("div_lo", lo, 32'd14);
      chk("div_hi", hi, 32'd2);
      chk("div_out", alu_out, 32'd14);
      single("mfhi", 4'b1010, 32'h0, 32'h0, 32'd2);
      single("mflo", 4'b1011, 32'h0, 32'h0, 32'd14);
      run_multi(4'b1000, 32'd6, 32'd7, 1'b0);
      chk("mul2_hi", hi, 32'd0);
      chk("mul2_lo", lo, 32'd42);
      run_multi(4'b1001, 32'd7, 32'd100, 1'b0);
      chk("div2_lo", lo, 32'd0);
      chk("div2_hi", hi, 32'd7);
      chk("div2_zero", zero, 1'b1);
`ifdef SIGNED_MULDIV_EN
      run_multi(4'b1101, 32'hFFFF_FFFD, 32'd5, 1'b0);
      chk("mult_lat", lat, 34);
      chk("mult_busy", busy_n, 32);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);
      run_multi(4'b1101, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 1'b0);
      chk("mult_nn_hi", hi, 32'd0);
      chk("mult_nn_lo", lo, 32'd20);
      run_multi(4'b1110, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("sdiv_lat", lat, 34);
      chk("sdiv_lo", lo, 32'hFFFF_FFFD);
      chk("sdiv_hi", hi, 32'hFFFF_FFFF);
      run_multi(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("sdiv_min_lo", lo, 32'h8000_0000);
      chk("sdiv_min_hi", hi, 32'h0);
      run_multi(4'b1110, 32'hFFFF_FFF8, 32'd0, 1'b0);
      chk("sdiv0_lo", lo, 32'hFFFF_FFFF);
      chk("sdiv0_hi", hi, 32'hFFFF_FFF8);
`else
      single("op1101", 4'b1101, 32'hABCD, 32'h1, 32'hABCD);
      chk("op1101_busy", busy, 1'b0);
      single("op1110", 4'b1110, 32'h55, 32'h0, 32'h55);
`endif
      run_multi(4'b1001, 32'h1234, 32'd0, 1'b1);
      chk("div0_lat", lat, 33);
      chk("div0_ready", bad, 0);
      chk("div0_extra", extra, 0);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'h1234);
      chk("div0_zero", zero, 1'b0);
      issue(4'b1000, 32'd5, 32'd6);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 1'b0);
      chk("mid_ready", in_ready, 1'b1);
      chk("mid_hi", hi, 32'h0);
      chk("mid_lo", lo, 32'h0);
      chk("mid_out", alu_out, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ov_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) ov_n++;
      end
      chk("mid_nopulse", ov_n, 0);
      chk("mid_hi_after", hi, 32'h0);
      chk("mid_lo_after", lo, 32'h0);
      chk("mid_ready_after", in_ready, 1'b1);
      chk("mid_zero_after", zero, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
